// File: rtl/ab_pkg.sv
// ab_pkg: shared address-bus encodings for the micro-op base/offset fields and interrupt vector low bytes
package ab_pkg;

    // Base select codes carried in op[5:3]
    localparam logic [2:0] BASE_ZERO = 3'b000;
    localparam logic [2:0] BASE_ABL  = 3'b001;
    localparam logic [2:0] BASE_PCL  = 3'b010;
    localparam logic [2:0] BASE_DB   = 3'b011;
    localparam logic [2:0] BASE_REG  = 3'b100;
    localparam logic [2:0] BASE_VEC  = 3'b101;

    // Offset select codes carried in op[2:0]
    localparam logic [2:0] OFF_ZERO = 3'b000;
    localparam logic [2:0] OFF_ONE  = 3'b001;
    localparam logic [2:0] OFF_REG  = 3'b010;
    localparam logic [2:0] OFF_DB   = 3'b011;
    localparam logic [2:0] OFF_DEC  = 3'b100;

    // Interrupt vector low bytes
    localparam logic [7:0] VEC_NMI = 8'hFA;
    localparam logic [7:0] VEC_RST = 8'hFC;
    localparam logic [7:0] VEC_IRQ = 8'hFE;

    // Vector select: 0 NMI, 1 RESET, 2/3 IRQ/BRK
    function automatic logic [7:0] vec_lo(input logic [1:0] vec);
        return (vec == 2'd0) ? VEC_NMI : (vec == 2'd1) ? VEC_RST : VEC_IRQ;
    endfunction

endpackage

// File: rtl/abl.sv
// abl: address-bus-low stage; forms ADL = base + offset, registers ABL, PCL and the carry CO for the high stage
module abl
    import ab_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic [5:0] op,
    input  logic [7:0] DB,
    input  logic [7:0] REG,
    input  logic [1:0] vec,
    input  logic       ld_pc,
    input  logic       inc_pc,
    output logic [7:0] ADL,
    output logic [7:0] ABL,
    output logic [7:0] PCL,
    output logic       CO
);

    logic [7:0] abl_q, abl_d;
    logic [7:0] pcl_q, pcl_d;
    logic       co_q, co_d;
    logic [7:0] base, offset;
    logic [8:0] sum;
    logic       carry_en;
    logic [2:0] base_sel, off_sel;

    assign base_sel = op[5:3];
    assign off_sel  = op[2:0];

    // Select base and offset, add them; decrement and reserved offsets never report a carry
    always_comb begin
        base = (base_sel == BASE_ABL) ? abl_q :
               (base_sel == BASE_PCL) ? pcl_q :
               (base_sel == BASE_DB)  ? DB    :
               (base_sel == BASE_REG) ? REG   :
               (base_sel == BASE_VEC) ? vec_lo(vec) : 8'h00;
        offset = (off_sel == OFF_ONE) ? 8'h01 :
                 (off_sel == OFF_REG) ? REG   :
                 (off_sel == OFF_DB)  ? DB    :
                 (off_sel == OFF_DEC) ? 8'hFF : 8'h00;
        carry_en = (off_sel == OFF_ONE) || (off_sel == OFF_REG) || (off_sel == OFF_DB);
        sum = {1'b0, base} + {1'b0, offset};
    end

    // Next-state: reset wins over rdy; PCL loads from the pre-edge ABL
    always_comb begin
        abl_d = rst ? 8'h00 : rdy ? sum[7:0] : abl_q;
        co_d  = rst ? 1'b0  : rdy ? (carry_en & sum[8]) : co_q;
        pcl_d = rst ? 8'h00 : (rdy && ld_pc) ? abl_q + {7'd0, inc_pc} : pcl_q;
    end

    // State registers
    always_ff @(posedge clk) begin
        abl_q <= abl_d;
        pcl_q <= pcl_d;
        co_q  <= co_d;
    end

    assign ADL = sum[7:0];
    assign ABL = abl_q;
    assign PCL = pcl_q;
    assign CO  = co_q;

endmodule
